// File: rtl/teletype_io_controller_pkg.sv
// Shared definitions for the teletype I/O controller: output device code,
// FIO-DEC case-shift codes and FSM state encodings.
`ifndef TTY_DEV_TELETYPE
`define TTY_DEV_TELETYPE 2'd1
`endif

package teletype_io_controller_pkg;

  localparam logic [1:0] OUTPUT_TELETYPE = `TTY_DEV_TELETYPE;

  // FIO-DEC case-shift characters; echoed like any other key
  localparam logic [5:0] FIO_LOWER_CASE = 6'o72;
  localparam logic [5:0] FIO_UPPER_CASE = 6'o74;

  typedef enum logic [1:0] {IN_IDLE, IN_HELD, IN_POP, IN_HOLDOFF} in_state_t;
  typedef enum logic [1:0] {OUT_IDLE, OUT_SEND, OUT_DISCARD}      out_state_t;
  typedef enum logic       {RQ_CPU, RQ_ECHO}                      rq_t;

endpackage

// File: rtl/teletype_io_controller_if.sv
// Keyboard / CPU IOT / renderer signal bundle. The controller connects via
// the slave modport; the surrounding system drives the master side.
interface teletype_io_controller_if;
  logic       kbd_read_strobe;
  logic [6:0] kbd_char_in;
  logic       key_was_processed;
  logic [1:0] current_output_device;
  logic       tyi_flag;
  logic       tyi_sb_req;
  logic [5:0] tyi_data;
  logic       tyi_case;
  logic       tyi_ack;
  logic       tyo_req;
  logic [5:0] tyo_char;
  logic       tyo_busy;
  logic       tyo_done;
  logic [5:0] tty_char;
  logic       tty_valid;
  logic       tty_ready;

  modport slave (
    input  kbd_read_strobe, kbd_char_in, current_output_device, tyi_ack,
           tyo_req, tyo_char, tty_ready,
    output key_was_processed, tyi_flag, tyi_sb_req, tyi_data, tyi_case,
           tyo_busy, tyo_done, tty_char, tty_valid
  );

  modport master (
    output kbd_read_strobe, kbd_char_in, current_output_device, tyi_ack,
           tyo_req, tyo_char, tty_ready,
    input  key_was_processed, tyi_flag, tyi_sb_req, tyi_data, tyi_case,
           tyo_busy, tyo_done, tty_char, tty_valid
  );
endinterface

// File: rtl/teletype_io_controller_tty_rr_arbiter.sv
// Two-requester (CPU TYO vs keyboard echo) round-robin grant for the single
// teletype sink. Grants only while en is high; rr_last tracks the last winner.
module tty_rr_arbiter
  import teletype_io_controller_pkg::*;
(
  input  logic clk,
  input  logic rst,
  input  logic en,
  input  logic req_cpu,
  input  logic req_echo,
  output logic gnt_cpu,
  output logic gnt_echo
);

  rq_t rr_last;

  always_comb begin
    gnt_cpu  = 1'b0;
    gnt_echo = 1'b0;
    if (en) begin
      if (req_cpu && req_echo) begin
        if (rr_last == RQ_ECHO) gnt_cpu  = 1'b1;
        else                    gnt_echo = 1'b1;
      end else begin
        gnt_cpu  = req_cpu;
        gnt_echo = req_echo;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst)           rr_last <= RQ_ECHO;
    else if (gnt_cpu)  rr_last <= RQ_CPU;
    else if (gnt_echo) rr_last <= RQ_ECHO;
  end

endmodule

// File: rtl/teletype_io_controller.sv
// Keyboard FIFO -> TYI sequencer and TYO/echo arbiter for the teletype sink.
// Optional feature: define LOCAL_ECHO_EN to echo every latched key to the teletype.
module teletype_io_controller
  import teletype_io_controller_pkg::*;
#(
  parameter int HOLDOFF_CYCLES = 2,
  parameter int DISCARD_CYCLES = 16
) (
  input  logic                     clk,
  input  logic                     rst,
  teletype_io_controller_if.slave  io
);

  localparam int HCW = $clog2(HOLDOFF_CYCLES + 1);
  localparam int DCW = $clog2(DISCARD_CYCLES + 1);

  in_state_t  istate;
  out_state_t ostate;
  rq_t        owner;
  logic [HCW-1:0] hcnt;
  logic [DCW-1:0] dcnt;

  logic       tyi_flag, tyi_sb_req, tyi_case, kwp;
  logic [5:0] tyi_data;
  logic       tyo_busy, tyo_done, tty_valid;
  logic [5:0] tyo_buf, tty_char;

  logic       echo_full;
  logic [5:0] echo_char;
  logic       latch, dev_tty, cpu_pend, gnt_cpu, gnt_echo;

  assign dev_tty = (io.current_output_device == `TTY_DEV_TELETYPE);
  assign latch   = (istate == IN_IDLE) && io.kbd_read_strobe && !echo_full;
  // During the tyo_done cycle busy is still high but the char is already delivered
  assign cpu_pend = tyo_busy && !tyo_done;

  tty_rr_arbiter u_arb (
    .clk      (clk),
    .rst      (rst),
    .en       (ostate == OUT_IDLE),
    .req_cpu  (cpu_pend),
    .req_echo (echo_full),
    .gnt_cpu  (gnt_cpu),
    .gnt_echo (gnt_echo)
  );

`ifdef LOCAL_ECHO_EN
  logic echo_clr;
  assign echo_clr = (ostate == OUT_IDLE && gnt_echo && !dev_tty) ||
                    (ostate == OUT_SEND && owner == RQ_ECHO && tty_valid && io.tty_ready);

  always_ff @(posedge clk) begin
    if (rst) begin
      echo_full <= 1'b0;
      echo_char <= '0;
    end else if (latch) begin
      echo_full <= 1'b1;
      echo_char <= io.kbd_char_in[5:0];
    end else if (echo_clr) begin
      echo_full <= 1'b0;
    end
  end
`else
  assign echo_full = 1'b0;
  assign echo_char = '0;
`endif

  // Input FSM: latch key, wait for CPU ack, pop FIFO, let FIFO head settle
  always_ff @(posedge clk) begin
    if (rst) begin
      istate     <= IN_IDLE;
      tyi_flag   <= 1'b0;
      tyi_sb_req <= 1'b0;
      tyi_data   <= '0;
      tyi_case   <= 1'b0;
      kwp        <= 1'b0;
      hcnt       <= '0;
    end else begin
      tyi_sb_req <= 1'b0;
      kwp        <= 1'b0;
      case (istate)
        IN_IDLE: if (latch) begin
          {tyi_case, tyi_data} <= io.kbd_char_in;
          tyi_flag   <= 1'b1;
          tyi_sb_req <= 1'b1;
          istate     <= IN_HELD;
        end
        IN_HELD: if (io.tyi_ack) begin
          tyi_flag <= 1'b0;
          kwp      <= 1'b1;
          istate   <= IN_POP;
        end
        IN_POP: begin
          hcnt   <= HCW'(HOLDOFF_CYCLES - 1);
          istate <= IN_HOLDOFF;
        end
        IN_HOLDOFF: begin
          if (hcnt == '0) istate <= IN_IDLE;
          else            hcnt   <= hcnt - HCW'(1);
        end
        default: istate <= IN_IDLE;
      endcase
    end
  end

  // Output FSM plus TYO holding register
  always_ff @(posedge clk) begin
    if (rst) begin
      ostate    <= OUT_IDLE;
      owner     <= RQ_CPU;
      tyo_busy  <= 1'b0;
      tyo_buf   <= '0;
      tyo_done  <= 1'b0;
      tty_valid <= 1'b0;
      tty_char  <= '0;
      dcnt      <= '0;
    end else begin
      tyo_done <= 1'b0;
      if (io.tyo_req && (!tyo_busy || tyo_done)) begin
        tyo_busy <= 1'b1;
        tyo_buf  <= io.tyo_char;
      end else if (tyo_done) begin
        tyo_busy <= 1'b0;
      end

      case (ostate)
        OUT_IDLE: if (gnt_cpu || gnt_echo) begin
          owner <= gnt_echo ? RQ_ECHO : RQ_CPU;
          if (dev_tty) begin
            ostate    <= OUT_SEND;
            tty_valid <= 1'b1;
            tty_char  <= gnt_echo ? echo_char : tyo_buf;
          end else if (gnt_cpu) begin
            // tyo_done lands DISCARD_CYCLES cycles after this grant cycle
            ostate <= OUT_DISCARD;
            dcnt   <= DCW'(DISCARD_CYCLES - 2);
          end
        end
        OUT_SEND: if (io.tty_ready) begin
          tty_valid <= 1'b0;
          ostate    <= OUT_IDLE;
          if (owner == RQ_CPU) tyo_done <= 1'b1;
        end
        OUT_DISCARD: begin
          if (dcnt == '0) begin
            tyo_done <= 1'b1;
            ostate   <= OUT_IDLE;
          end else begin
            dcnt <= dcnt - DCW'(1);
          end
        end
        default: ostate <= OUT_IDLE;
      endcase
    end
  end

  assign io.key_was_processed = kwp;
  assign io.tyi_flag          = tyi_flag;
  assign io.tyi_sb_req        = tyi_sb_req;
  assign io.tyi_data          = tyi_data;
  assign io.tyi_case          = tyi_case;
  assign io.tyo_busy          = tyo_busy;
  assign io.tyo_done          = tyo_done;
  assign io.tty_char          = tty_char;
  assign io.tty_valid         = tty_valid;

endmodule

// File: tb/tb_teletype_io_controller.sv
// Directed bench for teletype_io_controller: per-cycle vector table plus
// hand-written sequences for FIFO draining, arbitration order and reset.
module tb_teletype_io_controller;
  import teletype_io_controller_pkg::*;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  teletype_io_controller_if bus();

  teletype_io_controller dut (
    .clk (clk),
    .rst (rst),
    .io  (bus.slave)
  );

  typedef struct {
    int         id;
    logic       s;
    logic [6:0] k;
    logic       a;
    logic       tq;
    logic [5:0] tc;
    logic [1:0] d;
    logic       r;
    logic       fl, sb;
    logic [5:0] dt;
    logic       cs, kw, bz, dn, vl;
    logic [5:0] tt;
  } vec_t;

  localparam logic [1:0] DEV_TTY = OUTPUT_TELETYPE;
  localparam logic [1:0] DEV_OFF = 2'd0;
  localparam logic [6:0] K61  = 7'o061;
  localparam logic [6:0] K62  = 7'o062;
  localparam logic [6:0] K63  = 7'o063;
  localparam logic [6:0] K145 = 7'o145;

  int checks = 0;
  int errors = 0;
  vec_t vt[$];

  function automatic vec_t mk(int id, logic s, logic [6:0] k, logic a, logic tq, logic [5:0] tc,
                              logic [1:0] d, logic r, logic fl, logic sb, logic [5:0] dt, logic cs,
                              logic kw, logic bz, logic dn, logic vl, logic [5:0] tt);
    vec_t v;
    v.id = id; v.s = s; v.k = k; v.a = a; v.tq = tq; v.tc = tc; v.d = d; v.r = r;
    v.fl = fl; v.sb = sb; v.dt = dt; v.cs = cs; v.kw = kw; v.bz = bz; v.dn = dn; v.vl = vl; v.tt = tt;
    return v;
  endfunction

  task automatic idle_inputs();
    bus.kbd_read_strobe = 1'b0;
    bus.kbd_char_in = '0;
    bus.tyi_ack = 1'b0;
    bus.tyo_req = 1'b0;
    bus.tyo_char = '0;
    bus.current_output_device = DEV_OFF;
    bus.tty_ready = 1'b0;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check1(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h expected %0h", name, got, exp);
    end
  endtask

  task automatic do_reset();
    idle_inputs();
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
  endtask

  initial begin
    logic [6:0] seen[$];
    logic [6:0] fifo[$];
    logic [5:0] sent[$];
    logic [6:0] g7;
    logic [5:0] g6;
    logic [23:0] got_w, exp_w;
    int pops;

    // Test 1: single key handshake, holdoff, ack outside HELD, case bit
    vt.push_back(mk(1, 1, K61, 0, 0, 0, DEV_OFF, 0, 1, 1, 6'o61, 0, 0, 0, 0, 0, 0));
    vt.push_back(mk(1, 1, K61, 0, 0, 0, DEV_OFF, 0, 1, 0, 6'o61, 0, 0, 0, 0, 0, 0));
    vt.push_back(mk(1, 1, K61, 1, 0, 0, DEV_OFF, 0, 0, 0, 6'o61, 0, 1, 0, 0, 0, 0));
    vt.push_back(mk(1, 1, K62, 0, 0, 0, DEV_OFF, 0, 0, 0, 6'o61, 0, 0, 0, 0, 0, 0));
    vt.push_back(mk(1, 1, K62, 1, 0, 0, DEV_OFF, 0, 0, 0, 6'o61, 0, 0, 0, 0, 0, 0));
    vt.push_back(mk(1, 1, K62, 0, 0, 0, DEV_OFF, 0, 0, 0, 6'o61, 0, 0, 0, 0, 0, 0));
    vt.push_back(mk(1, 1, K62, 0, 0, 0, DEV_OFF, 0, 1, 1, 6'o62, 0, 0, 0, 0, 0, 0));
    vt.push_back(mk(1, 0, 0,   1, 0, 0, DEV_OFF, 0, 0, 0, 6'o62, 0, 1, 0, 0, 0, 0));
    for (int i = 0; i < 3; i++)
      vt.push_back(mk(1, 0, 0, 0, 0, 0, DEV_OFF, 0, 0, 0, 6'o62, 0, 0, 0, 0, 0, 0));
    vt.push_back(mk(1, 0, 0,    1, 0, 0, DEV_OFF, 0, 0, 0, 6'o62, 0, 0, 0, 0, 0, 0));
    vt.push_back(mk(1, 1, K145, 0, 0, 0, DEV_OFF, 0, 1, 1, 6'o45, 1, 0, 0, 0, 0, 0));
    vt.push_back(mk(1, 0, 0,    1, 0, 0, DEV_OFF, 0, 0, 0, 6'o45, 1, 1, 0, 0, 0, 0));
    for (int i = 0; i < 3; i++)
      vt.push_back(mk(1, 0, 0, 0, 0, 0, DEV_OFF, 0, 0, 0, 6'o45, 1, 0, 0, 0, 0, 0));

    // Test 3: teletype stalls 5 cycles, TYO while busy dropped, done on accept
    vt.push_back(mk(3, 0, 0, 0, 1, 6'o20, DEV_TTY, 0, 0, 0, 6'o45, 1, 0, 1, 0, 0, 0));
    vt.push_back(mk(3, 0, 0, 0, 0, 0,     DEV_TTY, 0, 0, 0, 6'o45, 1, 0, 1, 0, 1, 6'o20));
    vt.push_back(mk(3, 0, 0, 0, 0, 0,     DEV_TTY, 0, 0, 0, 6'o45, 1, 0, 1, 0, 1, 6'o20));
    vt.push_back(mk(3, 0, 0, 0, 1, 6'o77, DEV_TTY, 0, 0, 0, 6'o45, 1, 0, 1, 0, 1, 6'o20));
    for (int i = 0; i < 3; i++)
      vt.push_back(mk(3, 0, 0, 0, 0, 0, DEV_TTY, 0, 0, 0, 6'o45, 1, 0, 1, 0, 1, 6'o20));
    vt.push_back(mk(3, 0, 0, 0, 0, 0, DEV_TTY, 1, 0, 0, 6'o45, 1, 0, 1, 1, 0, 0));
    vt.push_back(mk(3, 0, 0, 0, 0, 0, DEV_TTY, 0, 0, 0, 6'o45, 1, 0, 0, 0, 0, 0));
    vt.push_back(mk(3, 0, 0, 0, 0, 0, DEV_TTY, 0, 0, 0, 6'o45, 1, 0, 0, 0, 0, 0));

    // Test 4: discard timing, TYO in the done cycle, device change during SEND
    vt.push_back(mk(4, 0, 0, 0, 1, 6'o21, DEV_OFF, 0, 0, 0, 6'o45, 1, 0, 1, 0, 0, 0));
    for (int i = 1; i <= 15; i++)
      vt.push_back(mk(4, 0, 0, 0, 0, 0, DEV_OFF, 0, 0, 0, 6'o45, 1, 0, 1, 0, 0, 0));
    vt.push_back(mk(4, 0, 0, 0, 0, 0,     DEV_OFF, 0, 0, 0, 6'o45, 1, 0, 1, 1, 0, 0));
    vt.push_back(mk(4, 0, 0, 0, 1, 6'o22, DEV_TTY, 0, 0, 0, 6'o45, 1, 0, 1, 0, 0, 0));
    vt.push_back(mk(4, 0, 0, 0, 0, 0,     DEV_TTY, 0, 0, 0, 6'o45, 1, 0, 1, 0, 1, 6'o22));
    vt.push_back(mk(4, 0, 0, 0, 0, 0,     DEV_OFF, 0, 0, 0, 6'o45, 1, 0, 1, 0, 1, 6'o22));
    vt.push_back(mk(4, 0, 0, 0, 0, 0,     DEV_OFF, 1, 0, 0, 6'o45, 1, 0, 1, 1, 0, 0));
    vt.push_back(mk(4, 0, 0, 0, 0, 0,     DEV_OFF, 0, 0, 0, 6'o45, 1, 0, 0, 0, 0, 0));

    // Reset state
    do_reset();
    check1("reset_outputs",
           {bus.tyi_flag, bus.tyi_sb_req, bus.tyi_data, bus.tyi_case, bus.key_was_processed,
            bus.tyo_busy, bus.tyo_done, bus.tty_valid, bus.tty_char}, 32'h0);

    // Test 2: three-key FIFO drained by an acking CPU
    fifo = '{K61, K62, K63};
    pops = 0;
    for (int c = 0; c < 40; c++) begin
      bus.kbd_read_strobe = (fifo.size() > 0);
      bus.kbd_char_in = (fifo.size() > 0) ? fifo[0] : 7'h0;
      bus.tyi_ack = bus.tyi_flag;
      tick();
      if (bus.tyi_sb_req) seen.push_back({bus.tyi_case, bus.tyi_data});
      if (bus.key_was_processed) begin
        pops++;
        if (fifo.size() > 0) void'(fifo.pop_front());
      end
    end
    idle_inputs();
    check1("fifo_pop_count", pops, 3);
    for (int i = 0; i < 3; i++) begin
      g7 = (i < seen.size()) ? seen[i] : 7'h7f;
      check1($sformatf("fifo_data_%0d", i), g7, (i == 0) ? K61 : (i == 1) ? K62 : K63);
    end

    // Table-driven tests 1, 3, 4
    for (int i = 0; i < vt.size(); i++) begin
      bus.kbd_read_strobe = vt[i].s;
      bus.kbd_char_in = vt[i].k;
      bus.tyi_ack = vt[i].a;
      bus.tyo_req = vt[i].tq;
      bus.tyo_char = vt[i].tc;
      bus.current_output_device = vt[i].d;
      bus.tty_ready = vt[i].r;
      tick();
      got_w = {bus.tyi_flag, bus.tyi_sb_req, bus.tyi_data, bus.tyi_case, bus.key_was_processed,
               bus.tyo_busy, bus.tyo_done, bus.tty_valid, vt[i].vl ? bus.tty_char : 6'h0};
      exp_w = {vt[i].fl, vt[i].sb, vt[i].dt, vt[i].cs, vt[i].kw,
               vt[i].bz, vt[i].dn, vt[i].vl, vt[i].tt};
      checks++;
      if (got_w !== exp_w) begin
        errors++;
        $display("FAIL test%0d row %0d got %06h expected %06h", vt[i].id, i, got_w, exp_w);
      end
    end
    idle_inputs();

`ifdef LOCAL_ECHO_EN
    // Test 5: key and TYO together after reset -> CPU char first, echo second
    do_reset();
    bus.current_output_device = DEV_TTY;
    bus.tty_ready = 1'b1;
    bus.kbd_read_strobe = 1'b1;
    bus.kbd_char_in = K61;
    bus.tyo_req = 1'b1;
    bus.tyo_char = 6'o20;
    tick();
    bus.kbd_read_strobe = 1'b0;
    bus.tyo_req = 1'b0;
    for (int c = 0; c < 12; c++) begin
      if (bus.tty_valid) sent.push_back(bus.tty_char);
      tick();
    end
    check1("arb_count", sent.size(), 2);
    g6 = (sent.size() > 0) ? sent[0] : 6'h3f;
    check1("arb_first_cpu", g6, 6'o20);
    g6 = (sent.size() > 1) ? sent[1] : 6'h3f;
    check1("arb_second_echo", g6, 6'o61);
    idle_inputs();
`endif

    // Test 6: reset during SEND with a held TYI char
    do_reset();
    bus.current_output_device = DEV_TTY;
    bus.tyo_req = 1'b1;
    bus.tyo_char = 6'o23;
    tick();
    bus.tyo_req = 1'b0;
    bus.kbd_read_strobe = 1'b1;
    bus.kbd_char_in = {1'b0, FIO_UPPER_CASE};
    tick();
    bus.kbd_read_strobe = 1'b0;
    check1("pre_rst_state", {bus.tty_valid, bus.tyo_busy, bus.tyi_flag, bus.tyi_data}, {3'b111, FIO_UPPER_CASE});
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check1("rst_tty_valid", bus.tty_valid, 0);
    check1("rst_tyo_busy", bus.tyo_busy, 0);
    check1("rst_tyi_flag", bus.tyi_flag, 0);
    bus.tty_ready = 1'b1;
    tick();
    tick();
    check1("post_rst_quiet", {bus.tty_valid, bus.tyo_busy, bus.tyo_done, bus.tyi_flag, bus.key_was_processed}, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
